// File: rtl/div_pkg.sv
// Purpose : shared constants and state encoding for the sequential divider.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    // Default operand / quotient / remainder width.
    localparam int DIV_WIDTH = 32;

    // Iteration counter width for the default width.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Controller state encoding (2 bits, value 3 unused).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// Purpose : one combinational radix-2 restoring division iteration.
// Latency : combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   rem_i, quo_i  working remainder / quotient before the iteration
//   divisor_i     divisor magnitude
//   rem_o, quo_o  working remainder / quotient after the iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] sh_rem;
    logic [WIDTH:0] trial;
    logic           trial_ok;

    // {rem,quo} shifted left: the quotient MSB enters the remainder LSB.
    // The shifted remainder is below 2*divisor, so WIDTH+1 bits hold both
    // it and the signed trial difference.
    assign sh_rem   = {rem_i, quo_i[WIDTH-1]};
    assign trial    = sh_rem - {1'b0, divisor_i};
    assign trial_ok = ~trial[WIDTH];

    assign rem_o = trial_ok ? trial[WIDTH-1:0] : sh_rem[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], trial_ok};

endmodule

// File: rtl/divider.sv
// Purpose : sequential radix-2 restoring divider with divide-by-zero flag.
// Latency : WIDTH cycles from the start edge to op_done; 1 cycle for divisor=0.
// Backpressure: op_start is a level request, ignored outside IDLE; op_clear aborts/releases.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   dividend, divisor       operands, sampled only on the start edge
//   op_start, op_clear      start request / synchronous clear (clear wins)
//   op_done                 high while a result is held
//   quotient, remainder     result, zero except while op_done is high
//   div_by_zero             high with op_done when the sampled divisor was 0
//
// Build option: define DIVIDER_SIGNED_EN for two's-complement truncating
// division; the unsigned core runs on magnitudes and the result is
// sign-corrected as it loads into the output registers.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             op_start,
    input  logic             op_clear,
    output logic             op_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             done_q;
    logic             dbz_q;

    // Operand magnitudes fed to the core, and final sign-corrected results.
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef DIVIDER_SIGNED_EN
    logic qneg_q;
    logic rneg_q;

    // The most-negative value negates to itself, which is its correct
    // unsigned magnitude; most-negative / -1 therefore yields
    // most-negative with remainder 0 without a special case.
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_fin   = qneg_q ? -quo_d : quo_d;
    assign r_fin   = rneg_q ? -rem_d : rem_d;

    // Result signs recorded on the start edge: quotient negative when the
    // operand signs differ, remainder follows the dividend.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == IDLE && op_start && !op_clear) begin
            qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_fin   = quo_d;
    assign r_fin   = rem_d;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (rem_d),
        .quo_o    (quo_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else if (op_clear) begin
            // Clear aborts any division and drops the held result.
            state_q     <= IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        if (divisor == '0) begin
                            // No iterations needed: report immediately.
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= EXEC;
                            rem_q   <= '0;
                            quo_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            cnt_q   <= '0;
                        end
                    end
                end
                EXEC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Final iteration also loads the visible result.
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        quotient_q  <= q_fin;
                        remainder_q <= r_fin;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                DONE: begin
                    // Result held; op_start has no effect until cleared.
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign op_done     = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
